// File: rtl/inv_subbytes_seq.sv
// InvSubBytes sequencer: streams a 128-bit AES state through NUM_SBOX shared
// inverse S-boxes, NUM_SBOX bytes per cycle, with valid/ready on both sides.

module inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] p, input logic [7:0] q);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h00;
        s = p;
        for (int i = 0; i < 8; i++) begin
            if (q[i]) r = r ^ s;
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1B : 8'h00);
        end
        return r;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 so every input is covered
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] t;

    // Inverse affine transform precedes the field inversion
    assign t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    assign y = gf_inv(t);
endmodule

module inv_subbytes_seq #(
    parameter int unsigned NUM_SBOX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int unsigned STEPS = 16 / NUM_SBOX;
    localparam int unsigned GW    = 8 * NUM_SBOX;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 ||
          NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_num_sbox
        $error("inv_subbytes_seq: NUM_SBOX must be 1, 2, 4, 8 or 16");
    end

    logic [1:0]    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [127:0]  work, result, result_d;
    logic [GW-1:0] grp_in, grp_out;
    logic          load, upd, fin;
    logic          ready_d, valid_d, busy_d;

    for (genvar s = 0; s < NUM_SBOX; s++) begin : g_sbox
        inv_sbox u_sbox (
            .a (grp_in[8*s +: 8]),
            .y (grp_out[8*s +: 8])
        );
    end

    // Select the byte group addressed by cnt
    always_comb begin
        grp_in = '0;
        for (int g = 0; g < STEPS; g++) begin
            if (cnt == CW'(g)) grp_in = work[g*GW +: GW];
        end
    end

    // Merge the substituted group into the result image
    always_comb begin
        result_d = result;
        for (int g = 0; g < STEPS; g++) begin
            if (cnt == CW'(g)) result_d[g*GW +: GW] = grp_out;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        load    = 1'b0;
        upd     = 1'b0;
        fin     = 1'b0;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        load    = 1'b1;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    upd   = 1'b1;
                    cnt_d = cnt + CW'(1);
                    if (cnt == CW'(STEPS - 1)) begin
                        fin     = 1'b1;
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        // out_valid rises on the second DONE cycle, giving STEPS+1 latency
        valid_d = (state_d == DONE) && (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work      <= '0;
            result    <= '0;
            out_data  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (load) work <= in_data;
            if (upd && !flush) result <= result_d;
            if (fin) out_data <= result_d;
            in_ready  <= ready_d;
            out_valid <= valid_d;
            busy      <= busy_d;
        end
    end
endmodule
